// File: rtl/fir_mac_seq_if.sv
// fir_mac_seq_if: sample, result and coefficient-load signals of fir_mac_seq.
// master drives samples/coefficients, slave is the filter.
interface fir_mac_seq_if #(
   parameter int DATA_W  = 16,
   parameter int COEFF_W = 16,
   parameter int TAPS    = 20,
   parameter int OUT_W   = 32
);
   logic                        in_valid;
   logic                        in_ready;
   logic signed [DATA_W-1:0]    in_data;
   logic                        out_valid;
   logic signed [OUT_W-1:0]     out_data;
   logic                        coeff_we;
   logic [$clog2(TAPS)-1:0]     coeff_addr;
   logic signed [COEFF_W-1:0]   coeff_data;
   logic                        busy;
   modport master (
      output in_valid, in_data, coeff_we, coeff_addr, coeff_data,
      input  in_ready, out_valid, out_data, busy
   );
   modport slave (
      input  in_valid, in_data, coeff_we, coeff_addr, coeff_data,
      output in_ready, out_valid, out_data, busy
   );
endinterface

// File: rtl/fir_mac_seq.sv
// fir_mac_seq: time-multiplexed single-multiplier FIR with loadable coefficients and saturated output.
// Define FIR_SYMMETRIC_EN for linear-phase folding (ceil(TAPS/2) coefficients and MAC cycles).
module fir_mac_seq #(
   parameter int DATA_W    = 16,
   parameter int COEFF_W   = 16,
   parameter int TAPS      = 20,
   parameter int OUT_W     = 32,
   parameter int OUT_SHIFT = 0
) (
   input logic          clk,
   input logic          rst,
   fir_mac_seq_if.slave bus
);
   localparam int AW    = $clog2(TAPS);
   localparam int ACC_W = DATA_W + COEFF_W + $clog2(TAPS) + 1;
   localparam int SW    = ACC_W > OUT_W ? ACC_W : OUT_W;
`ifdef FIR_SYMMETRIC_EN
   localparam int NC = (TAPS + 1) / 2;
`else
   localparam int NC = TAPS;
`endif
   localparam logic signed [SW-1:0] OMAX = SW'({1'b0, {(OUT_W-1){1'b1}}});
   localparam logic signed [SW-1:0] OMIN = ~OMAX;
   typedef enum logic {IDLE, MAC} state_t;
   state_t                     state;
   logic signed [DATA_W-1:0]   x [TAPS];
   logic signed [COEFF_W-1:0]  h [NC];
   logic [AW-1:0]              idx;
   logic signed [ACC_W-1:0]    acc, sum;
   logic signed [DATA_W:0]     tap;
   logic signed [DATA_W+COEFF_W:0] prod;
   logic signed [SW-1:0]       sh;
   logic signed [OUT_W-1:0]    sat_v;
   logic                       last;
   assign bus.in_ready = state == IDLE;
   assign bus.busy     = state == MAC;
   always_comb begin
      last = idx == AW'(NC - 1);
      tap  = (DATA_W+1)'(x[idx]);
`ifdef FIR_SYMMETRIC_EN
      // odd-length middle tap has no mirror partner
      if (!(TAPS % 2 == 1 && last)) tap = tap + (DATA_W+1)'(x[AW'(TAPS - 1) - idx]);
`endif
      prod  = tap * h[idx];
      sum   = acc + ACC_W'(prod);
      sh    = SW'(sum >>> OUT_SHIFT);
      sat_v = sh > OMAX ? OMAX[OUT_W-1:0] : sh < OMIN ? OMIN[OUT_W-1:0] : sh[OUT_W-1:0];
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= IDLE;
         idx           <= '0;
         acc           <= '0;
         bus.out_valid <= 1'b0;
         bus.out_data  <= '0;
         for (int i = 0; i < TAPS; i++) x[i] <= '0;
         for (int i = 0; i < NC; i++) h[i] <= '0;
      end else begin
         bus.out_valid <= 1'b0;
         if (state == IDLE) begin
            if (bus.coeff_we && {1'b0, bus.coeff_addr} < (AW+1)'(NC)) h[bus.coeff_addr] <= bus.coeff_data;
            if (bus.in_valid) begin
               x[0] <= bus.in_data;
               for (int i = 1; i < TAPS; i++) x[i] <= x[i-1];
               idx   <= '0;
               acc   <= '0;
               state <= MAC;
            end
         end else begin
            acc <= sum;
            idx <= idx + AW'(1);
            if (last) begin
               bus.out_data  <= sat_v;
               bus.out_valid <= 1'b1;
               state         <= IDLE;
            end
         end
      end
   end
endmodule

// File: tb/tb_fir_mac_seq.sv
// tb_fir_mac_seq: scoreboard bench; accepted samples are scored against a plain sum-of-products
// model with clamping, and results are popped and compared whenever out_valid is seen.
`timescale 1ns/1ps
module tb_fir_mac_seq;
   localparam int DATA_W = 16, COEFF_W = 16, TAPS = 20, OUT_W = 32;
`ifdef FIR_SYMMETRIC_EN
   localparam int NC = (TAPS + 1) / 2;
`else
   localparam int NC = TAPS;
`endif
   localparam longint OMAX = (longint'(1) << (OUT_W - 1)) - 1;
   localparam longint OMIN = -(longint'(1) << (OUT_W - 1));
   typedef struct { longint val; int t; } exp_t;
   logic   clk = 0, rst = 1;
   int     cyc = 0, n_chk = 0, n_fail = 0, n_acc = 0, n_out = 0, last_acc = -1, n0 = 0;
   bit     bp = 0, r = 0;
   longint last_out = 0;
   longint hist [TAPS];
   longint hm [NC];
   exp_t   sb [$];
   fir_mac_seq_if #(.DATA_W(DATA_W), .COEFF_W(COEFF_W), .TAPS(TAPS), .OUT_W(OUT_W)) bus ();
   fir_mac_seq #(.DATA_W(DATA_W), .COEFF_W(COEFF_W), .TAPS(TAPS), .OUT_W(OUT_W), .OUT_SHIFT(0)) dut (
      .clk(clk), .rst(rst), .bus(bus));
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   task automatic chk(input string nm, input longint act, input longint exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at cycle %0d", nm, act, exp, cyc);
      end
   endtask
   // effective coefficient applied to delay-line position k
   function automatic longint heff(input int k);
`ifdef FIR_SYMMETRIC_EN
      return hm[k < NC ? k : TAPS - 1 - k];
`else
      return hm[k];
`endif
   endfunction
   always @(posedge clk) begin
      if (rst) begin
         n_acc -= sb.size();
         sb.delete();
         last_acc = -1;
         foreach (hm[k]) hm[k] = 0;
         foreach (hist[k]) hist[k] = 0;
      end else if (bus.in_ready) begin
         if (bus.coeff_we && int'(bus.coeff_addr) < NC) hm[bus.coeff_addr] = longint'(bus.coeff_data);
         if (bus.in_valid) begin
            longint s;
            s = 0;
            for (int k = TAPS - 1; k > 0; k--) hist[k] = hist[k-1];
            hist[0] = longint'(bus.in_data);
            for (int k = 0; k < TAPS; k++) s += hist[k] * heff(k);
            sb.push_back('{s > OMAX ? OMAX : s < OMIN ? OMIN : s, cyc + 1});
            if (bp && last_acc >= 0) chk("accept_spacing", cyc - last_acc, NC + 1);
            last_acc = cyc;
            n_acc++;
         end
      end
   end
   always @(negedge clk) begin
      if (!rst) begin
         chk("busy_vs_ready", longint'(bus.busy), longint'(!bus.in_ready));
         if (bus.out_valid) begin
            n_out++;
            last_out = bus.out_data;
            if (sb.size() == 0) begin
               n_chk++;
               n_fail++;
               $display("FAIL unexpected_out_valid: got out_data %0d, required no result", bus.out_data);
            end else begin
               exp_t e;
               e = sb.pop_front();
               chk("out_data", bus.out_data, e.val);
               chk("latency", cyc - e.t, NC);
            end
         end
      end
   end
   task automatic wait_ready(input string nm);
      int n = 0;
      while (!bus.in_ready && n < 200) begin @(negedge clk); n++; end
      chk(nm, n < 200, 1);
   endtask
   task automatic send(input longint d);
      wait_ready("send_timeout");
      bus.in_valid = 1;
      bus.in_data  = DATA_W'(d);
      @(negedge clk);
      bus.in_valid = 0;
   endtask
   task automatic load(input int a, input longint d);
      wait_ready("load_timeout");
      bus.coeff_we   = 1;
      bus.coeff_addr = $clog2(TAPS)'(a);
      bus.coeff_data = COEFF_W'(d);
      @(negedge clk);
      bus.coeff_we = 0;
   endtask
   task automatic drain();
      int n = 0;
      while ((!bus.in_ready || sb.size() != 0) && n < 200) begin @(negedge clk); n++; end
      chk("drain_timeout", n < 200, 1);
      @(negedge clk);
   endtask
   task automatic pulse_rst();
      rst = 1;
      repeat (2) @(negedge clk);
      rst = 0;
   endtask
   task automatic chk_reset_outputs(input string nm);
      chk({nm, "_out_valid"}, bus.out_valid, 0);
      chk({nm, "_out_data"}, bus.out_data, 0);
      chk({nm, "_in_ready"}, bus.in_ready, 1);
      chk({nm, "_busy"}, bus.busy, 0);
   endtask
   initial begin
      bus.in_valid = 0; bus.in_data = '0; bus.coeff_we = 0; bus.coeff_addr = '0; bus.coeff_data = '0;
      repeat (3) @(negedge clk);
      chk_reset_outputs("reset");
      rst = 0;
      // impulse through ramp coefficients
      for (int k = 0; k < NC; k++) load(k, k + 1);
      send(1);
      repeat (20) send(0);
      drain();
      chk("impulse_tail", last_out, 0);
      // saturation both ways
      pulse_rst();
      for (int k = 0; k < NC; k++) load(k, 32767);
      repeat (20) send(32767);
      drain();
      chk("sat_max", last_out, OMAX);
      repeat (20) send(-32768);
      drain();
      chk("sat_min", last_out, OMIN);
      // back-pressure: in_valid held high
      last_acc = -1;
      bp = 1;
      n0 = n_acc;
      bus.in_valid = 1;
      bus.in_data  = 16'sd5;
      for (int i = 0; i < 5 * (NC + 1); i++) begin
         r = bus.in_ready;
         @(negedge clk);
         if (r) bus.in_data = bus.in_data + 16'sd1;
      end
      bus.in_valid = 0;
      drain();
      bp = 0;
      chk("bp_accepts", n_acc - n0, 5);
      // coefficient write while busy is ignored
      pulse_rst();
      for (int k = 0; k < NC; k++) load(k, 1);
      send(1);
      bus.coeff_we = 1; bus.coeff_addr = '0; bus.coeff_data = 16'sd100;
      @(negedge clk);
      bus.coeff_we = 0;
      drain();
      chk("busy_write_ignored", last_out, 1);
      // reset at MAC cycle 7
      send(5);
      repeat (6) @(negedge clk);
      rst = 1;
      @(negedge clk);
      rst = 0;
      chk_reset_outputs("midmac");
      drain();
      send(1);
      drain();
      chk("post_reset_zero", last_out, 0);
      // randomized traffic with random coefficient writes
      for (int k = 0; k < NC; k++) load(k, $urandom_range(0, 400) - 200);
      for (int i = 0; i < 1500; i++) begin
         bus.in_valid   = $urandom_range(0, 2) != 0;
         bus.in_data    = $urandom_range(0, 3) == 0 ? 16'($urandom) : 16'($urandom_range(0, 200)) - 16'sd100;
         bus.coeff_we   = $urandom_range(0, 5) == 0;
         bus.coeff_addr = 5'($urandom);
         bus.coeff_data = $urandom_range(0, 3) == 0 ? 16'($urandom) : 16'($urandom_range(0, 400)) - 16'sd200;
         @(negedge clk);
      end
      bus.in_valid = 0;
      bus.coeff_we = 0;
      drain();
      chk("out_count", n_out, n_acc);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not complete, %0d assertions, %0d failures", n_chk, n_fail);
      $fatal(1, "watchdog");
   end
endmodule

// File: doc/fir_mac_seq.md
Name: fir_mac_seq

Overview:
- Parametrised successor to the fixed 20-tap parallel FIR. Time-multiplexed, single-multiplier FIR on one clock.
- Samples arrive on a valid/ready strobe, not a separate sample clock. Coefficients are runtime-loadable; output is shifted and saturated.
- Sits between the accelerometer sample path and the downstream game/position logic.

Parameters:
- DATA_W, 16: signed input sample width.
- COEFF_W, 16: signed coefficient width.
- TAPS, 20: filter length; minimum 2.
- OUT_W, 32: signed output width.
- OUT_SHIFT, 0: arithmetic right shift applied to the accumulator before saturation.
- ACC_W (localparam): DATA_W+COEFF_W+clog2(TAPS)+1.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  sample present.
- in_ready  out  1  block can accept a sample.
- in_data  in  DATA_W  signed sample.
- out_valid  out  1  one-cycle result strobe.
- out_data  out  OUT_W  signed filtered result.
- coeff_we  in  1  coefficient write enable.
- coeff_addr  in  clog2(TAPS)  coefficient index.
- coeff_data  in  COEFF_W  signed coefficient value.
- busy  out  1  MAC in progress.

Behaviour:
- Interface: one clock; reset is synchronous and active-high (clk, rst).
- Reset:
  - state=IDLE; delay line x[0..TAPS-1]=0; all coefficients h[]=0; accumulator=0.
  - out_valid=0, out_data=0, in_ready=1, busy=0.
- States: IDLE and MAC.
- IDLE:
  - in_ready=1, busy=0.
  - Sample accepted on an edge where in_valid&&in_ready: x[k]<=x[k-1], x[0]<=in_data, idx<=0, acc<=0, state<=MAC.
- MAC:
  - in_ready=0, busy=1. Each edge: acc<=acc+x[idx]*h[idx] (full-precision signed), idx<=idx+1.
  - On the edge adding idx=TAPS-1:
    - out_data<=sat(final_sum>>>OUT_SHIFT), where final_sum includes that last product.
    - out_valid<=1; state<=IDLE.
- Latency: out_valid is high in the cycle following the TAPS-th MAC edge, i.e. TAPS cycles after the acceptance edge.
- Throughput: one sample per TAPS+1 cycles. A new sample may be accepted in the same cycle out_valid is high.
- out_valid: high for exactly one cycle per accepted sample. out_data holds its value until the next result or reset.
- Saturation: values >2^(OUT_W-1)-1 clamp to max; values <-2^(OUT_W-1) clamp to min. No wrap-around.
- in_valid while in_ready=0: ignored, no sample lost silently beyond this. The producer must hold or drop per the handshake.
- Coefficient writes:
  - Applied on the edge only when state=IDLE and coeff_addr<TAPS; otherwise ignored.
  - Same-edge coeff write plus sample acceptance: the write takes effect and is used by that sample's MAC.
- rst asserted mid-MAC: the computation is aborted with no out_valid, and everything takes its reset values, coefficients included.

Optional Feature:
- Macro: FIR_SYMMETRIC_EN.
- Defined:
  - Linear-phase mode. Only NC=ceil(TAPS/2) coefficient registers; coeff_addr>=NC is ignored.
  - MAC step k uses (x[k]+x[TAPS-1-k])*h[k] with a DATA_W+1 pre-adder. For odd TAPS, the middle tap is x[k]*h[k] with no pre-add.
  - MAC runs NC cycles, so latency=NC and throughput is one sample per NC+1 cycles.
- Undefined: general asymmetric FIR as above, TAPS coefficients, TAPS-cycle MAC.

Test Plan:
- Impulse (TAPS=20, no macro):
  - Stimulus: h[k]=k+1; feed 1 then nineteen 0s, each accepted as soon as in_ready.
  - Response: out_data sequence 1,2,...,20; a further 0 input gives 0. Each out_valid arrives exactly 20 cycles after its acceptance edge.
- Saturation:
  - Stimulus: all h=32767; twenty inputs of 32767.
  - Response: 20th out_data=2147483647. Repeat with inputs -32768: out_data=-2147483648.
- Back-pressure:
  - Stimulus: hold in_valid=1 continuously, data 5,6,7,...
  - Response: in_ready low for 20 cycles after each acceptance; exactly one sample accepted per 21 cycles; out_valid count equals accepted count.
- Coefficient write while busy:
  - Stimulus: h[]=1 in IDLE; feed 1; during MAC write h[0]=100.
  - Response: out_data=1. The write is ignored, and h[0] still reads as 1 via the next impulse result.
- Reset mid-MAC:
  - Stimulus: load h, feed a sample, assert rst for 1 cycle at MAC cycle 7.
  - Response: no out_valid; in_ready=1 next cycle; all outputs at reset values; the next impulse gives 0 because coefficients were cleared.
- FIR_SYMMETRIC_EN (TAPS=5):
  - Stimulus: h[0..2]=1,2,3; impulse input.
  - Response: outputs 1,2,3,2,1, each 3 cycles after acceptance.
